// File: rtl/interboard_pkg.sv
`default_nettype none
// ============================================================================
// interboard_pkg : shared definitions for the 6-bit inter-board link
// Rev 1.0
// ============================================================================
package interboard_pkg;

    localparam int BEAT_W     = 6;
    localparam int MARKER_BIT = 5;

    localparam logic [2:0] MSG_RST = 3'b111;

    // Beat payload below the marker bit: beat 0 and beat 1 layouts.
    typedef struct packed {
        logic [2:0] msg_type;
        logic [1:0] num_hi;
    } beat0_t;

    typedef struct packed {
        logic [1:0] pad;
        logic [2:0] num_lo;
    } beat1_t;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ACK0  = 2'd1;
    localparam state_t ST_WAIT1 = 2'd2;
    localparam state_t ST_ACK1  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/interboard_if.sv
`default_nettype none
// ============================================================================
// interboard_if : request/acknowledge link wires between the two boards
// Rev 1.0
// ============================================================================
interface interboard_if;
    logic       Request_in;
    logic [5:0] inter_data_in;
    logic       Ack_out;

    modport master (output Request_in, output inter_data_in, input Ack_out);
    modport slave  (input Request_in, input inter_data_in, output Ack_out);
endinterface
`default_nettype wire

// File: rtl/interboard_sync.sv
`default_nettype none
// ============================================================================
// interboard_sync : 2-FF synchronizer for a single asynchronous level
// Rev 1.0
// ============================================================================
module interboard_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/interboard_receiver.sv
`default_nettype none
// ============================================================================
// interboard_receiver : 4-phase handshake receiver, two beats -> one message
// Rev 1.0
// ============================================================================
module interboard_receiver
    import interboard_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic         clk,
    input  logic         rst,
    interboard_if.slave  link,
    output logic         interboard_en,
    output logic [2:0]   interboard_msg_type,
    output logic [4:0]   interboard_number,
    output logic         interboard_rst,
    output logic         frame_err
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic   req_s;
    logic   w_marker;
    beat0_t w_b0;
    beat1_t w_b1;

    state_t        state_q, state_d;
    logic          ack_q, ack_d;
    logic          discard_q, discard_d;
    beat0_t        beat0_q, beat0_d;
    beat1_t        beat1_q, beat1_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          en_q, en_d;
    logic          rstp_q, rstp_d;
    logic          err_q, err_d;
    logic [2:0]    type_q, type_d;
    logic [4:0]    num_q, num_d;

    interboard_sync u_req_sync (
        .clk (clk),
        .rst (rst),
        .d_i (link.Request_in),
        .q_o (req_s)
    );

    assign w_marker = link.inter_data_in[MARKER_BIT];
    assign w_b0     = beat0_t'(link.inter_data_in[MARKER_BIT-1:0]);
    assign w_b1     = beat1_t'(link.inter_data_in[MARKER_BIT-1:0]);

    always_comb begin
        state_d   = state_q;
        ack_d     = ack_q;
        discard_d = discard_q;
        beat0_d   = beat0_q;
        beat1_d   = beat1_q;
        timer_d   = timer_q;
        en_d      = 1'b0;
        rstp_d    = 1'b0;
        err_d     = 1'b0;
        type_d    = type_q;
        num_d     = num_q;

        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    beat0_d   = w_b0;
                    ack_d     = 1'b1;
                    discard_d = ~w_marker;
                    err_d     = ~w_marker;
                    state_d   = ST_ACK0;
                end
            end
            ST_ACK0: begin
                if (!req_s) begin
                    ack_d   = 1'b0;
                    timer_d = '0;
                    state_d = discard_q ? ST_IDLE : ST_WAIT1;
                end
            end
            ST_WAIT1: begin
                if (req_s) begin
                    ack_d = 1'b1;
                    if (w_marker) begin
                        // Sender restarted: the new beat becomes beat 0.
                        err_d     = 1'b1;
                        beat0_d   = w_b0;
                        discard_d = 1'b0;
                        state_d   = ST_ACK0;
                    end else begin
                        beat1_d = w_b1;
                        state_d = ST_ACK1;
                    end
                end else if (timer_q == T_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_ACK1: begin
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = ST_IDLE;
                    if (beat1_q.pad != 2'b00) begin
                        err_d = 1'b1;
                    end else if (beat0_q.msg_type == MSG_RST) begin
                        rstp_d = 1'b1;
                    end else begin
                        en_d   = 1'b1;
                        type_d = beat0_q.msg_type;
                        num_d  = {beat0_q.num_hi, beat1_q.num_lo};
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ack_q     <= 1'b0;
            discard_q <= 1'b0;
            beat0_q   <= '0;
            beat1_q   <= '0;
            timer_q   <= '0;
            en_q      <= 1'b0;
            rstp_q    <= 1'b0;
            err_q     <= 1'b0;
            type_q    <= '0;
            num_q     <= '0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            discard_q <= discard_d;
            beat0_q   <= beat0_d;
            beat1_q   <= beat1_d;
            timer_q   <= timer_d;
            en_q      <= en_d;
            rstp_q    <= rstp_d;
            err_q     <= err_d;
            type_q    <= type_d;
            num_q     <= num_d;
        end
    end

    assign link.Ack_out        = ack_q;
    assign interboard_en       = en_q;
    assign interboard_rst      = rstp_q;
    assign frame_err           = err_q;
    assign interboard_msg_type = type_q;
    assign interboard_number   = num_q;

endmodule
`default_nettype wire

// File: tb/tb_interboard_receiver.sv
`default_nettype none
// ============================================================================
// tb_interboard_receiver : directed self-checking bench, TIMEOUT_CYCLES = 16
// Rev 1.0
// ============================================================================
module tb_interboard_receiver;

    logic       clk;
    logic       rst;
    logic       interboard_en;
    logic [2:0] interboard_msg_type;
    logic [4:0] interboard_number;
    logic       interboard_rst;
    logic       frame_err;

    int n_tests;
    int n_fail;
    int en_cnt, rst_cnt, err_cnt, multi_cnt;
    int en0, rst0, err0;

    interboard_if link ();

    interboard_receiver #(.TIMEOUT_CYCLES(16)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .link                (link),
        .interboard_en       (interboard_en),
        .interboard_msg_type (interboard_msg_type),
        .interboard_number   (interboard_number),
        .interboard_rst      (interboard_rst),
        .frame_err           (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            en_cnt  <= en_cnt + int'(interboard_en);
            rst_cnt <= rst_cnt + int'(interboard_rst);
            err_cnt <= err_cnt + int'(frame_err);
            if ((int'(interboard_en) + int'(interboard_rst) + int'(frame_err)) > 1)
                multi_cnt <= multi_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ack(input logic val, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk); #1;
            if (link.Ack_out === val) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic send_beat(input logic [5:0] b, input string tag);
        @(posedge clk); #1;
        link.inter_data_in = b;
        link.Request_in    = 1'b1;
        wait_ack(1'b1, {tag, "_ackhi"});
        link.Request_in = 1'b0;
        wait_ack(1'b0, {tag, "_acklo"});
    endtask

    task automatic snap();
        @(negedge clk);
        en0  = en_cnt;
        rst0 = rst_cnt;
        err0 = err_cnt;
    endtask

    task automatic check_deltas(input string tag, input int de, input int dr, input int dx);
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check({tag, "_en"},  32'(en_cnt - en0),   32'(de));
        check({tag, "_rst"}, 32'(rst_cnt - rst0), 32'(dr));
        check({tag, "_err"}, 32'(err_cnt - err0), 32'(dx));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] lag;
        logic       early;
        n_tests = 0; n_fail = 0;
        en_cnt = 0; rst_cnt = 0; err_cnt = 0; multi_cnt = 0;
        link.Request_in    = 1'b0;
        link.inter_data_in = 6'd0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("reset_ack",  32'(link.Ack_out), 32'd0);
        check("reset_type", 32'(interboard_msg_type), 32'd0);
        check("reset_num",  32'(interboard_number), 32'd0);
        check("reset_strb", 32'({interboard_en, interboard_rst, frame_err}), 32'd0);

        // Normal message with explicit 3-cycle handshake lag.
        snap();
        @(posedge clk); #1;
        link.inter_data_in = 6'b1_010_10;
        link.Request_in    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            lag[2-i] = link.Ack_out;
        end
        check("lag_rise", 32'(lag), 32'b001);
        link.Request_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            lag[2-i] = link.Ack_out;
        end
        check("lag_fall", 32'(lag), 32'b110);
        send_beat(6'b0_00_011, "m1_b1");
        check("m1_en_with_ackfall", 32'(interboard_en), 32'd1);
        check("m1_type", 32'(interboard_msg_type), 32'b010);
        check("m1_num",  32'(interboard_number), 32'b10011);
        check_deltas("m1", 1, 0, 0);

        // MSG_RST: type/number must hold previous values.
        snap();
        send_beat(6'b1_111_00, "rst_b0");
        send_beat(6'b0_00_000, "rst_b1");
        check("rst_type", 32'(interboard_msg_type), 32'b010);
        check("rst_num",  32'(interboard_number), 32'b10011);
        check_deltas("rstmsg", 0, 1, 0);

        // Nonzero pad in beat 1.
        snap();
        send_beat(6'b1_001_11, "pad_b0");
        send_beat(6'b0_01_000, "pad_b1");
        check("pad_type", 32'(interboard_msg_type), 32'b010);
        check_deltas("pad", 0, 0, 1);

        // Beat 0 with marker clear while idle.
        snap();
        send_beat(6'b0_101_01, "mk0");
        check_deltas("mk0", 0, 0, 1);

        // Timeout after beat 0; WAIT1 entered on the edge Ack falls.
        snap();
        send_beat(6'b1_011_01, "to_b0");
        early = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            if (i < 16) early = early | frame_err;
            else check("to_err_at16", 32'(frame_err), 32'd1);
        end
        check("to_early", 32'(early), 32'd0);
        send_beat(6'b1_100_01, "to_m_b0");
        send_beat(6'b0_00_101, "to_m_b1");
        check("to_m_type", 32'(interboard_msg_type), 32'b100);
        check("to_m_num",  32'(interboard_number), 32'b01101);
        check_deltas("to", 1, 0, 1);

        // Resync: second beat 0 replaces the first.
        snap();
        send_beat(6'b1_010_11, "rs_b0a");
        send_beat(6'b1_001_01, "rs_b0b");
        send_beat(6'b0_00_100, "rs_b1");
        check("rs_type", 32'(interboard_msg_type), 32'b001);
        check("rs_num",  32'(interboard_number), 32'b01100);
        check_deltas("rs", 1, 0, 1);

        // Reset while Ack is high in ACK1.
        snap();
        send_beat(6'b1_110_10, "rr_b0");
        @(posedge clk); #1;
        link.inter_data_in = 6'b0_00_001;
        link.Request_in    = 1'b1;
        wait_ack(1'b1, "rr_b1_ackhi");
        rst = 1'b1;
        link.Request_in = 1'b0;
        @(posedge clk); #1;
        check("rr_ack_dropped", 32'(link.Ack_out), 32'd0);
        rst = 1'b0;
        check("rr_type", 32'(interboard_msg_type), 32'd0);
        check("rr_num",  32'(interboard_number), 32'd0);
        check_deltas("rr", 0, 0, 0);
        snap();
        send_beat(6'b1_011_11, "rr_m_b0");
        send_beat(6'b0_00_010, "rr_m_b1");
        check("rr_m_type", 32'(interboard_msg_type), 32'b011);
        check("rr_m_num",  32'(interboard_number), 32'b11010);
        check_deltas("rr_m", 1, 0, 0);

        check("strobes_onehot", 32'(multi_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
